input_packer: RTL and testbench

Streaming front-end stage that accepts raw multi-pixel input beats, binarizes every pixel with the existing per-pixel threshold stage (pixel >= 128 -> 1), and packs the resulting bits into OUT_WIDTH-bit words for the first fully-connected layer. It tracks image boundaries with an internal pixel counter. It zero-pads the final partial word of each image and marks it with out_last. Both sides use a valid/ready handshake.

---
 rtl/bnn_pkg.sv | 14 +
 rtl/input_packer_if.sv | 30 +++
 rtl/binarize_input.sv | 13 +
 rtl/input_packer.sv | 109 ++++++++++
 tb/tb_input_packer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
// Shared constants for the binarized-network front end: pixel format,
// binarization threshold and derived packing geometry.
package bnn_pkg;

    localparam int unsigned INPUT_DATA_WIDTH = 8;
    localparam int unsigned IMAGE_PIXELS     = 784;
    localparam int unsigned BIN_THRESHOLD    = 128;
    localparam int unsigned IN_LANES         = 8;
    localparam int unsigned OUT_WIDTH        = 64;

    localparam int unsigned WORDS_PER_IMAGE  = (IMAGE_PIXELS + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int unsigned BEATS_PER_WORD   = OUT_WIDTH / IN_LANES;

endpackage

// File: rtl/input_packer_if.sv
// Valid/ready bundle for input_packer: raw pixel beats in, packed binary words out.
interface input_packer_if
    import bnn_pkg::*;
#(
    parameter int unsigned P_DATA_W = INPUT_DATA_WIDTH,
    parameter int unsigned P_LANES  = IN_LANES,
    parameter int unsigned P_OUT_W  = OUT_WIDTH
);

    logic                          in_valid;
    logic                          in_ready;
    logic [P_LANES*P_DATA_W-1:0]   in_data;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [P_OUT_W-1:0]            out_data;
    logic                          out_last;

    // slave: the packer itself; master: the upstream/downstream environment
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/binarize_input.sv
// Per-pixel threshold stage: a pixel at or above the shared threshold maps to 1.
module binarize_input
    import bnn_pkg::*;
#(
    parameter int unsigned DATA_W = INPUT_DATA_WIDTH
) (
    input  logic [DATA_W-1:0] i_pixel,
    output logic              o_bit
);

    assign o_bit = (i_pixel >= DATA_W'(BIN_THRESHOLD));

endmodule

// File: rtl/input_packer.sv
// Binarizes multi-pixel beats and packs the bits LSB-first into OUT_WIDTH-bit words,
// zero-padding the last word of each image. Optional in_last checking: INPUT_PACKER_LAST_CHECK_EN.
module input_packer
    import bnn_pkg::*;
#(
    parameter int unsigned P_DATA_W = INPUT_DATA_WIDTH,
    parameter int unsigned P_LANES  = IN_LANES,
    parameter int unsigned P_OUT_W  = OUT_WIDTH,
    parameter int unsigned P_PIXELS = IMAGE_PIXELS
) (
    input  logic           clk,
    input  logic           rst_n,
    input_packer_if.slave  bus,
    output logic           last_err
);

    localparam int unsigned BEATS_W  = P_OUT_W / P_LANES;
    localparam int unsigned CNT_W    = $clog2(P_PIXELS);
    localparam int unsigned SLOT_W   = (BEATS_W > 1) ? $clog2(BEATS_W) : 1;
    localparam int unsigned LAST_CNT = P_PIXELS - P_LANES;

    if ((P_OUT_W % P_LANES) != 0) begin : g_bad_out_width
        $error("OUT_WIDTH must be a multiple of IN_LANES");
    end
    if ((P_PIXELS % P_LANES) != 0) begin : g_bad_pixels
        $error("IMAGE_PIXELS must be a multiple of IN_LANES");
    end

    logic [CNT_W-1:0]   r_pix_cnt;
    logic [SLOT_W-1:0]  r_slot;
    logic [P_OUT_W-1:0] r_acc;
    logic [P_OUT_W-1:0] r_out_data;
    logic               r_out_valid;
    logic               r_out_last;

    logic [P_LANES-1:0] w_bits;
    logic [P_OUT_W-1:0] w_acc_next;
    logic               w_accept;
    logic               w_img_end;
    logic               w_word_full;
    logic               w_emit;

    for (genvar i = 0; i < P_LANES; i++) begin : g_lane
        binarize_input #(.DATA_W(P_DATA_W)) u_bin (
            .i_pixel (bus.in_data[i*P_DATA_W +: P_DATA_W]),
            .o_bit   (w_bits[i])
        );
    end

    // r_slot tracks (pix_cnt mod OUT_WIDTH) / IN_LANES without a general modulo
    assign w_accept    = bus.in_valid && bus.in_ready;
    assign w_img_end   = (r_pix_cnt == CNT_W'(LAST_CNT));
    assign w_word_full = (r_slot == SLOT_W'(BEATS_W - 1));
    assign w_emit      = w_word_full || w_img_end;
    assign w_acc_next  = r_acc | (P_OUT_W'(w_bits) << (r_slot * P_LANES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt   <= '0;
            r_slot      <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pix_cnt <= w_img_end ? '0 : r_pix_cnt + CNT_W'(P_LANES);
                if (w_emit) begin
                    r_acc  <= '0;
                    r_slot <= '0;
                end else begin
                    r_acc  <= w_acc_next;
                    r_slot <= r_slot + SLOT_W'(1);
                end
            end
            // a new load wins over an accept of the previous word on the same edge
            if (w_accept && w_emit) begin
                r_out_data  <= w_acc_next;
                r_out_valid <= 1'b1;
                r_out_last  <= w_img_end;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = !r_out_valid || bus.out_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;

`ifdef INPUT_PACKER_LAST_CHECK_EN
    logic r_last_err;

    // sticky: upstream marker disagrees with the internal boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_err <= 1'b0;
        end else if (w_accept && (bus.in_last != w_img_end)) begin
            r_last_err <= 1'b1;
        end
    end

    assign last_err = r_last_err;
`else
    assign last_err = 1'b0;
`endif

endmodule

// File: tb/tb_input_packer.sv
// Scoreboard bench for input_packer: directed images, backpressure, reset and in_last checks.
module tb_input_packer;
    import bnn_pkg::*;

    localparam int unsigned BEATS = IMAGE_PIXELS / IN_LANES;
    localparam int unsigned IN_W  = IN_LANES * INPUT_DATA_WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    logic last_err;

    always #5 clk = ~clk;

    input_packer_if bus ();

    input_packer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .last_err (last_err)
    );

    int total = 0;
    int bad   = 0;
    int beats_acc = 0;
    int stalls    = 0;

    logic [7:0]         img [IMAGE_PIXELS];
    logic [OUT_WIDTH:0] exp_q [$];
    logic [OUT_WIDTH:0] cap_q [$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: a word transfers on the edge following a sample with valid && ready
    initial begin
        logic [OUT_WIDTH:0] got;
        logic [OUT_WIDTH:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                got = {bus.out_last, bus.out_data};
                cap_q.push_back(got);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word got=%h exp=none", got);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", got[OUT_WIDTH-1:0], e[OUT_WIDTH-1:0]);
                    chk("word_last", 64'(got[OUT_WIDTH]), 64'(e[OUT_WIDTH]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic void fill_pattern(input int seed);
        for (int p = 0; p < int'(IMAGE_PIXELS); p++) img[p] = 8'(p * seed + 13);
    endfunction

    function automatic void push_expected(input int nwords);
        logic [OUT_WIDTH:0] e;
        for (int w = 0; w < nwords; w++) begin
            e = '0;
            for (int b = 0; b < int'(OUT_WIDTH); b++) begin
                if (w * int'(OUT_WIDTH) + b < int'(IMAGE_PIXELS))
                    e[b] = (img[w*int'(OUT_WIDTH)+b] >= 8'd128);
            end
            e[OUT_WIDTH] = (w == int'(WORDS_PER_IMAGE) - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic send_beat(input logic [IN_W-1:0] d, input logic lst);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = lst;
        #1;
        while (bus.in_ready !== 1'b1) begin
            stalls++;
            n++;
            if (n > 500) begin
                total++;
                bad++;
                $display("FAIL beat_timeout got=stalled exp=accept");
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        beats_acc++;
    endtask

    task automatic send_range(input int b0, input int b1, input int lb);
        logic [IN_W-1:0] d;
        for (int b = b0; b < b1; b++) begin
            for (int l = 0; l < int'(IN_LANES); l++) d[l*8 +: 8] = img[b*int'(IN_LANES)+l];
            send_beat(d, b == lb);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0 pending words", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [63:0] hold;
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_out_data",  bus.out_data,       64'd0);
        chk("rst_last_err",  64'(last_err),      64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single image of 200s: 12 all-ones words then a 16-bit tail
        for (int p = 0; p < int'(IMAGE_PIXELS); p++) img[p] = 8'd200;
        for (int w = 0; w < 12; w++) exp_q.push_back({1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        exp_q.push_back({1'b1, 64'h0000_0000_0000_FFFF});
        cap_q.delete();
        stalls = 0;
        send_range(0, BEATS, BEATS - 1);
        idle();
        drain();
        chk("img1_stalls", 64'(stalls), 64'd0);
        chk("img1_words",  64'(cap_q.size()), 64'd13);

        // Threshold-edge first beat, then a second image back-to-back
        fill_pattern(37);
        img[0] = 8'd127; img[1] = 8'd128; img[2] = 8'd0;   img[3] = 8'd255;
        img[4] = 8'd129; img[5] = 8'd1;   img[6] = 8'd128; img[7] = 8'd127;
        push_expected(13);
        cap_q.delete();
        send_range(0, BEATS, BEATS - 1);
        fill_pattern(91);
        img[0] = 8'd200;
        push_expected(13);
        send_range(0, BEATS, BEATS - 1);
        idle();
        drain();
        chk("b2b_words", 64'(cap_q.size()), 64'd26);
        if (cap_q.size() == 26) begin
            chk("thresh_byte",   64'(cap_q[0][7:0]), 64'h5A);
            chk("b2b_last_w12",  64'(cap_q[11][OUT_WIDTH]), 64'd0);
            chk("b2b_last_w13",  64'(cap_q[12][OUT_WIDTH]), 64'd1);
            chk("b2b_last_w26",  64'(cap_q[25][OUT_WIDTH]), 64'd1);
            chk("b2b_w14_bit0",  64'(cap_q[13][0]), 64'd1);
        end

        // Backpressure on the first word of an image
        fill_pattern(53);
        push_expected(13);
        cap_q.delete();
        beats_acc = 0;
        fork
            send_range(0, BEATS, BEATS - 1);
            begin
                @(negedge clk);
                bus.out_ready = 1'b0;
                n = 0;
                #1;
                while (bus.out_valid !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                hold = bus.out_data;
                chk("bp_beats_at_word", 64'(beats_acc), 64'd8);
                repeat (6) begin
                    @(negedge clk);
                    #1;
                    chk("bp_valid_held", 64'(bus.out_valid), 64'd1);
                    chk("bp_data_stable", bus.out_data, hold);
                    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
                end
                chk("bp_beats_held", 64'(beats_acc), 64'd8);
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        idle();
        drain();
        chk("bp_words", 64'(cap_q.size()), 64'd13);

        // Reset after 50 beats discards the partial word
        fill_pattern(29);
        push_expected(6);
        send_range(0, 50, -1);
        idle();
        drain();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_out_data",  bus.out_data, 64'd0);
        chk("mrst_out_last",  64'(bus.out_last), 64'd0);
        chk("mrst_in_ready",  64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        fill_pattern(71);
        push_expected(13);
        cap_q.delete();
        send_range(0, BEATS, BEATS - 1);
        idle();
        drain();
        chk("mrst_words", 64'(cap_q.size()), 64'd13);

        // Misplaced in_last on beat 50; boundaries still follow the counter
        fill_pattern(113);
        push_expected(13);
        cap_q.delete();
        send_range(0, 50, 49);
        idle();
        #1;
`ifdef INPUT_PACKER_LAST_CHECK_EN
        chk("lerr_set", 64'(last_err), 64'd1);
`else
        chk("lerr_tied", 64'(last_err), 64'd0);
`endif
        send_range(50, BEATS, -1);
        idle();
        drain();
        chk("lerr_words", 64'(cap_q.size()), 64'd13);
        if (cap_q.size() == 13) chk("lerr_out_last", 64'(cap_q[12][OUT_WIDTH]), 64'd1);
`ifdef INPUT_PACKER_LAST_CHECK_EN
        chk("lerr_sticky", 64'(last_err), 64'd1);
`else
        chk("lerr_tied_end", 64'(last_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
